ysyx_23060072_pipe_ctrl: RTL and testbench

- Central hazard and redirect controller for the two-stage pipeline (IF stage -> ID/EX stage).
- Inputs: branch resolution, traps/mret and stall requests from ID/EX, LSU and MDU.
- Drives the IF stage redirect (clean_flag/jump_pc), the IF hold, and a bubble into ID/EX.
- Sequences redirects that arrive during an LSU transaction, and counts mispredicts and stall cycles.

---
 rtl/ysyx_23060072_pipe_ctrl_pkg.sv | 29 ++
 rtl/ysyx_23060072_sat_cnt.sv | 20 ++
 rtl/ysyx_23060072_pipe_ctrl.sv | 152 +++++++++++++++
 tb/tb_ysyx_23060072_pipe_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060072_pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/redirect controller.
`ifndef YSYX_23060072_PIPE_CTRL_DEFS
`define YSYX_23060072_PIPE_CTRL_DEFS
`define YSYX_23060072_ENABLE  1'b1
`define YSYX_23060072_DISABLE 1'b0
`endif

package ysyx_23060072_pipe_ctrl_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned FC_W = 2;
  localparam int unsigned PRIO_W = 2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic [PRIO_W-1:0] PRIO_BR   = 2'd0;
  localparam logic [PRIO_W-1:0] PRIO_MRET = 2'd1;
  localparam logic [PRIO_W-1:0] PRIO_TRAP = 2'd2;

  typedef struct packed {
    logic [PRIO_W-1:0] prio;
    logic [XLEN-1:0]   pc;
  } redirect_t;

endpackage

// File: rtl/ysyx_23060072_sat_cnt.sv
// Saturating up-counter with asynchronous active-low clear.
module ysyx_23060072_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc, stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/ysyx_23060072_pipe_ctrl.sv
// Hazard and redirect controller for the IF -> ID/EX pipeline.
module ysyx_23060072_pipe_ctrl
  import ysyx_23060072_pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_br_valid_i,
  input  logic             ex_br_taken_i,
  input  logic [31:0]      ex_br_target_i,
  input  logic [31:0]      ex_pc_i,
  input  logic             ex_predict_flag_i,
  input  logic [31:0]      ex_pred_target_i,
  input  logic             trap_req_i,
  input  logic [31:0]      trap_vec_i,
  input  logic             mret_i,
  input  logic [31:0]      mepc_i,
  input  logic             load_use_i,
  input  logic             lsu_busy_i,
  input  logic             mdu_busy_i,
  output logic             clean_flag_o,
  output logic [31:0]      jump_pc_o,
  output logic             if_hold_flag_o,
  output logic             id_flush_o,
  output logic [CNT_W-1:0] mispred_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  state_e          state, state_nxt;
  redirect_t       pend, pend_nxt, req_c, sel_c, issue_rd_c;
  logic [FC_W-1:0] flush_cnt, flush_cnt_nxt;
  logic            clean_nxt, flush_nxt, issue_c;
  logic            mispred_c, req_valid_c, hold_c;
  logic [XLEN-1:0] jump_nxt;

  // Branch resolution: wrong direction, or taken to the wrong target.
  always_comb begin
    mispred_c = ex_br_valid_i &
                ((ex_br_taken_i ^ ex_predict_flag_i) |
                 (ex_br_taken_i & ex_predict_flag_i & (ex_br_target_i != ex_pred_target_i)));
  end

  // Pick the single highest-priority redirect request of this cycle.
  always_comb begin
    req_c.prio  = PRIO_BR;
    req_c.pc    = ex_br_taken_i ? ex_br_target_i : (ex_pc_i + 32'd4);
    req_valid_c = trap_req_i | mret_i | mispred_c;
    if (trap_req_i) begin
      req_c.prio = PRIO_TRAP;
      req_c.pc   = trap_vec_i;
    end else if (mret_i) begin
      req_c.prio = PRIO_MRET;
      req_c.pc   = mepc_i;
    end
  end

  // A parked redirect is only displaced by a strictly higher-priority one.
  always_comb begin
    sel_c = pend;
    if (req_valid_c && (req_c.prio > pend.prio)) begin
      sel_c = req_c;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt     = state;
    pend_nxt      = pend;
    issue_c       = `YSYX_23060072_DISABLE;
    issue_rd_c    = req_c;
    clean_nxt     = `YSYX_23060072_DISABLE;
    jump_nxt      = jump_pc_o;
    flush_nxt     = (flush_cnt != '0);
    flush_cnt_nxt = (flush_cnt != '0) ? (flush_cnt - FC_W'(1)) : '0;

    case (state)
      ST_PEND: begin
        if (!lsu_busy_i) begin
          issue_c    = `YSYX_23060072_ENABLE;
          issue_rd_c = sel_c;
        end else begin
          pend_nxt = sel_c;
        end
      end
      ST_RUN, ST_FLUSH: begin
        if (req_valid_c) begin
          if (lsu_busy_i) begin
            pend_nxt  = req_c;
            state_nxt = ST_PEND;
          end else begin
            issue_c    = `YSYX_23060072_ENABLE;
            issue_rd_c = req_c;
          end
        end else if ((state == ST_FLUSH) && (flush_cnt_nxt == '0)) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase

    if (issue_c) begin
      clean_nxt     = `YSYX_23060072_ENABLE;
      jump_nxt      = issue_rd_c.pc;
      flush_nxt     = `YSYX_23060072_ENABLE;
      flush_cnt_nxt = FC_W'(FLUSH_CYCLES - 1);
      state_nxt     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
    end
  end

  // State, pending slot and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_RUN;
      pend         <= '0;
      flush_cnt    <= '0;
      clean_flag_o <= 1'b0;
      jump_pc_o    <= '0;
      id_flush_o   <= 1'b0;
    end else begin
      state        <= state_nxt;
      pend         <= pend_nxt;
      flush_cnt    <= flush_cnt_nxt;
      clean_flag_o <= clean_nxt;
      jump_pc_o    <= jump_nxt;
      id_flush_o   <= flush_nxt;
    end
  end

  // IF hold; a redirect being issued or in flight overrides every stall source.
  always_comb begin
    hold_c = (load_use_i | lsu_busy_i | mdu_busy_i) & ~clean_flag_o & ~issue_c;
  end

  assign if_hold_flag_o = hold_c;

  ysyx_23060072_sat_cnt #(.W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mispred_c),
    .cnt   (mispred_cnt_o)
  );

  ysyx_23060072_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hold_c),
    .cnt   (stall_cnt_o)
  );

endmodule

// File: tb/tb_ysyx_23060072_pipe_ctrl.sv
// Scoreboard bench for the pipeline redirect controller.
module tb_ysyx_23060072_pipe_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ex_br_valid, ex_br_taken, ex_predict_flag;
  logic [31:0] ex_br_target, ex_pc, ex_pred_target;
  logic        trap_req, mret, load_use, lsu_busy, mdu_busy;
  logic [31:0] trap_vec, mepc;

  logic        clean_flag, if_hold_flag, id_flush;
  logic [31:0] jump_pc;
  logic [15:0] mispred_cnt, stall_cnt;

  logic        clean_flag4, if_hold_flag4, id_flush4;
  logic [31:0] jump_pc4;
  logic [3:0]  mispred_cnt4, stall_cnt4;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned exp_mis  = 0;
  int unsigned exp_mis4 = 0;
  int unsigned exp_stall = 0;
  logic [31:0] exp_q[$];

  ysyx_23060072_pipe_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ex_br_valid_i(ex_br_valid), .ex_br_taken_i(ex_br_taken),
    .ex_br_target_i(ex_br_target), .ex_pc_i(ex_pc),
    .ex_predict_flag_i(ex_predict_flag), .ex_pred_target_i(ex_pred_target),
    .trap_req_i(trap_req), .trap_vec_i(trap_vec), .mret_i(mret), .mepc_i(mepc),
    .load_use_i(load_use), .lsu_busy_i(lsu_busy), .mdu_busy_i(mdu_busy),
    .clean_flag_o(clean_flag), .jump_pc_o(jump_pc), .if_hold_flag_o(if_hold_flag),
    .id_flush_o(id_flush), .mispred_cnt_o(mispred_cnt), .stall_cnt_o(stall_cnt)
  );

  ysyx_23060072_pipe_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .ex_br_valid_i(ex_br_valid), .ex_br_taken_i(ex_br_taken),
    .ex_br_target_i(ex_br_target), .ex_pc_i(ex_pc),
    .ex_predict_flag_i(ex_predict_flag), .ex_pred_target_i(ex_pred_target),
    .trap_req_i(trap_req), .trap_vec_i(trap_vec), .mret_i(mret), .mepc_i(mepc),
    .load_use_i(load_use), .lsu_busy_i(lsu_busy), .mdu_busy_i(mdu_busy),
    .clean_flag_o(clean_flag4), .jump_pc_o(jump_pc4), .if_hold_flag_o(if_hold_flag4),
    .id_flush_o(id_flush4), .mispred_cnt_o(mispred_cnt4), .stall_cnt_o(stall_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_br_valid = 0; ex_br_taken = 0; ex_predict_flag = 0;
    ex_br_target = 0; ex_pc = 0; ex_pred_target = 0;
    trap_req = 0; trap_vec = 0; mret = 0; mepc = 0;
    load_use = 0; lsu_busy = 0; mdu_busy = 0;
  endtask

  task automatic note_mispred();
    exp_mis++;
    exp_mis4 = (exp_mis4 == 15) ? 15 : exp_mis4 + 1;
  endtask

  // Drive a mispredicting branch: actual direction/target vs prediction.
  task automatic drive_br(input logic taken, input logic [31:0] tgt, input logic [31:0] pc,
                          input logic pred, input logic [31:0] ptgt);
    ex_br_valid = 1; ex_br_taken = taken; ex_br_target = tgt;
    ex_pc = pc; ex_predict_flag = pred; ex_pred_target = ptgt;
  endtask

  // Check the combinational hold for the current inputs, then advance one cycle.
  task automatic step(input string tag, input logic exp_hold);
    #1;
    check({tag, "_hold"}, 32'(if_hold_flag), 32'(exp_hold));
    check({tag, "_hold4"}, 32'(if_hold_flag4), 32'(exp_hold));
    if (exp_hold) exp_stall++;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step("idle", 1'b0);
  endtask

  // Every clean pulse must match the next expected redirect target.
  always @(negedge clk) begin
    if (rst_n && clean_flag) begin
      if (exp_q.size() == 0) check("unexpected_clean", 32'(clean_flag), 32'd0);
      else check("jump_pc", jump_pc, exp_q.pop_front());
    end
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_clean", 32'(clean_flag), 32'd0);
    check("rst_jump", jump_pc, 32'd0);
    check("rst_hold", 32'(if_hold_flag), 32'd0);
    check("rst_flush", 32'(id_flush), 32'd0);
    check("rst_mis", 32'(mispred_cnt), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);
    check("rst_jump4", jump_pc4, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Predicted not-taken, resolved taken to 0x80.
    drive_br(1, 32'h80, 32'h40, 0, 32'h0);
    exp_q.push_back(32'h80); note_mispred();
    step("t1", 0);
    check("t1_clean", 32'(clean_flag), 32'd1);
    check("t1_flush", 32'(id_flush), 32'd1);
    check("t1_flush4", 32'(id_flush4), 32'd1);
    step("t1_idle", 0);
    check("t1_clean_off", 32'(clean_flag), 32'd0);
    check("t1_flush_off", 32'(id_flush), 32'd0);
    check("t1_flush4_2nd", 32'(id_flush4), 32'd1);
    check("t1_jump_held", jump_pc, 32'h80);
    check("t1_mis", 32'(mispred_cnt), 32'd1);
    step("t1_idle2", 0);
    check("t1_flush4_off", 32'(id_flush4), 32'd0);

    // Predicted taken, resolved not-taken; then wrong taken target.
    drive_br(0, 32'h100, 32'h3C, 1, 32'h100);
    exp_q.push_back(32'h40); note_mispred();
    step("t2a", 0);
    idle_cycles(2);
    drive_br(1, 32'h104, 32'h3C, 1, 32'h100);
    exp_q.push_back(32'h104); note_mispred();
    step("t2b", 0);
    idle_cycles(2);
    // Correct prediction: no redirect, no count.
    drive_br(1, 32'h100, 32'h3C, 1, 32'h100);
    step("t2c", 0);
    check("t2c_clean", 32'(clean_flag), 32'd0);
    idle_cycles(2);
    check("t2_mis", 32'(mispred_cnt), exp_mis);

    // Trap, mret and mispredict together: trap wins, mispredict still counted.
    drive_br(1, 32'h80, 32'h40, 0, 32'h0);
    trap_req = 1; trap_vec = 32'h200; mret = 1; mepc = 32'h300;
    exp_q.push_back(32'h200); note_mispred();
    step("t3", 0);
    check("t3_clean", 32'(clean_flag), 32'd1);
    idle_cycles(3);
    check("t3_mis", 32'(mispred_cnt), exp_mis);

    // Mispredict while LSU busy for 3 cycles.
    drive_br(1, 32'h80, 32'h40, 0, 32'h0); lsu_busy = 1;
    exp_q.push_back(32'h80); note_mispred();
    step("t4_b0", 1);
    check("t4_clean0", 32'(clean_flag), 32'd0);
    lsu_busy = 1;
    step("t4_b1", 1);
    check("t4_clean1", 32'(clean_flag), 32'd0);
    lsu_busy = 1;
    step("t4_b2", 1);
    check("t4_clean2", 32'(clean_flag), 32'd0);
    step("t4_rel", 0);
    check("t4_clean", 32'(clean_flag), 32'd1);
    idle_cycles(3);

    // Trap during PEND replaces the target; later mret is dropped.
    drive_br(1, 32'h80, 32'h40, 0, 32'h0); lsu_busy = 1; note_mispred();
    step("t5_b0", 1);
    trap_req = 1; trap_vec = 32'h240; lsu_busy = 1;
    exp_q.push_back(32'h240);
    step("t5_trap", 1);
    mret = 1; mepc = 32'h300; lsu_busy = 1;
    step("t5_mret", 1);
    step("t5_rel", 0);
    check("t5_clean", 32'(clean_flag), 32'd1);
    idle_cycles(3);

    // Load-use alone; then load-use and mdu with mispredicts.
    load_use = 1;
    step("t6_lu", 1);
    step("t6_after", 0);
    check("t6_stall", 32'(stall_cnt), exp_stall);
    load_use = 1; drive_br(1, 32'h180, 32'h40, 0, 32'h0);
    exp_q.push_back(32'h180); note_mispred();
    step("t6_lu_br", 0);
    check("t6_clean", 32'(clean_flag), 32'd1);
    idle_cycles(2);
    mdu_busy = 1; drive_br(0, 32'h0, 32'h1FC, 1, 32'h400);
    exp_q.push_back(32'h200); note_mispred();
    step("t6_mdu_br", 0);
    check("t6_mdu_clean", 32'(clean_flag), 32'd1);
    idle_cycles(2);
    check("t6_stall2", 32'(stall_cnt), exp_stall);

    // Back-to-back mispredicts: saturate the 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      drive_br(1, 32'h1000 + 32'(i) * 32'd4, 32'h40, 0, 32'h0);
      exp_q.push_back(32'h1000 + 32'(i) * 32'd4); note_mispred();
      step("t7", 0);
    end
    idle_cycles(3);
    check("t7_mis4", 32'(mispred_cnt4), exp_mis4);
    check("t7_mis", 32'(mispred_cnt), exp_mis);

    // Reset mid-PEND: everything clears and nothing issues afterwards.
    drive_br(1, 32'h500, 32'h40, 0, 32'h0); lsu_busy = 1;
    step("t8_pend", 1);
    lsu_busy = 1;
    #2;
    rst_n = 1'b0;
    #1;
    check("t8_clean", 32'(clean_flag), 32'd0);
    check("t8_jump", jump_pc, 32'd0);
    check("t8_flush", 32'(id_flush), 32'd0);
    check("t8_mis", 32'(mispred_cnt), 32'd0);
    check("t8_stall", 32'(stall_cnt), 32'd0);
    check("t8_mis4", 32'(mispred_cnt4), 32'd0);
    check("t8_stall4", 32'(stall_cnt4), 32'd0);
    lsu_busy = 0;
    exp_mis = 0; exp_mis4 = 0; exp_stall = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_cycles(4);
    check("t8_no_clean", 32'(clean_flag), 32'd0);
    check("t8_no_clean4", 32'(clean_flag4), 32'd0);
    check("t8_flush_post", 32'(id_flush), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
